// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, access-mode constants and memory size for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
  localparam logic MODE_WORD = 1'b0;
  localparam logic MODE_BYTE = 1'b1;
  localparam int MEM_BYTES_DEF = 2048;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-side request/response channel plus the data-memory strobe bus
interface load_store_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic req_valid, req_ready, req_write, req_byte, req_signed;
  logic [ADDR_W-1:0] req_addr, mem_address;
  logic [DATA_W-1:0] req_wdata, resp_data, mem_write_data, mem_read_data;
  logic resp_valid, resp_fault, mem_rd, mem_wn, mem_mode;
  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_data, resp_fault,
    input  mem_rd, mem_wn, mem_address, mem_mode, mem_write_data
  );
  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_data, resp_fault,
    output mem_rd, mem_wn, mem_address, mem_mode, mem_write_data
  );
endinterface

// File: rtl/load_extend.sv
// load_extend: turns raw big-endian memory data into load result (byte lane is the high byte)
module load_extend #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] raw,
  input  logic              byte_acc,
  input  logic              sgn,
  output logic [DATA_W-1:0] data
);
  logic [7:0] b;
  always_comb begin
    b = raw[DATA_W-1 -: 8];
    data = byte_acc ? {{(DATA_W-8){sgn & b[7]}}, b} : raw;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store controller for the byte-addressed data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 2);
  state_t state, state_n;
  logic sgn_q, accept, fault, go_access;
  logic [DATA_W-1:0] ext;
  always_comb begin
    accept = state == IDLE && bus.req_valid;
    fault = bus.req_addr > (bus.req_byte ? LAST_BYTE : LAST_WORD);
    go_access = accept && !fault;
    state_n = state == IDLE ? (accept ? (fault ? RESP : ACCESS) : IDLE) :
              state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Strobes are loaded on the accept edge so they are clean flops for the whole ACCESS cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sgn_q <= 1'b0;
      bus.mem_rd <= 1'b0;
      bus.mem_wn <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_mode <= MODE_WORD;
      bus.mem_write_data <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_data <= '0;
    end else begin
      sgn_q <= accept ? bus.req_signed : sgn_q;
      bus.mem_rd <= go_access && !bus.req_write;
      bus.mem_wn <= go_access && bus.req_write;
      bus.mem_address <= go_access ? bus.req_addr : '0;
      bus.mem_mode <= go_access && bus.req_byte ? MODE_BYTE : MODE_WORD;
      bus.mem_write_data <= go_access && bus.req_write ? bus.req_wdata : '0;
      bus.resp_valid <= state_n == RESP;
      bus.resp_fault <= accept && fault;
      bus.resp_data <= bus.mem_rd ? ext : '0;
    end
  assign bus.req_ready = state == IDLE;
  load_extend #(.DATA_W(DATA_W)) u_ext (
    .raw(bus.mem_read_data),
    .byte_acc(bus.mem_mode == MODE_BYTE),
    .sgn(sgn_q),
    .data(ext)
  );
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized checks of the LSU against a byte-array memory model
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wn_cnt = 0, resp_cnt = 0, excl_bad = 0, idle_bad = 0;
  logic [7:0] mem [0:2047];
  logic [7:0] ref_mem [0:2047];

  load_store_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  load_store_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_read_data = '0;
    if (bus.mem_rd && !bus.mem_wn && bus.mem_address < 16'd2048)
      bus.mem_read_data = {mem[bus.mem_address[10:0]],
                           bus.mem_address < 16'd2047 ? mem[bus.mem_address[10:0] + 11'd1] : 8'h00};
  end

  always @(negedge clk) begin
    if (bus.mem_wn) begin
      if (bus.mem_mode) mem[bus.mem_address[10:0]] <= bus.mem_write_data[7:0];
      else begin
        mem[bus.mem_address[10:0]] <= bus.mem_write_data[15:8];
        mem[bus.mem_address[10:0] + 11'd1] <= bus.mem_write_data[7:0];
      end
    end
    rd_cnt <= rd_cnt + (bus.mem_rd ? 1 : 0);
    wn_cnt <= wn_cnt + (bus.mem_wn ? 1 : 0);
    resp_cnt <= resp_cnt + (bus.resp_valid ? 1 : 0);
    excl_bad <= excl_bad + (bus.mem_rd && bus.mem_wn ? 1 : 0);
    idle_bad <= idle_bad + ((!bus.mem_rd && !bus.mem_wn &&
                 (bus.mem_address != 0 || bus.mem_mode || bus.mem_write_data != 0)) ||
                 (bus.mem_rd && bus.mem_write_data != 0) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic bit model_fault(int a, bit b);
    return a + (b ? 1 : 2) > 2048;
  endfunction

  function automatic logic [15:0] model_load(int a, bit b, bit s);
    int v;
    if (b) begin
      v = int'(ref_mem[a]);
      if (s && v >= 128) v = v - 256;
      return 16'(v);
    end
    return 16'(int'(ref_mem[a]) * 256 + int'(ref_mem[a + 1]));
  endfunction

  task automatic do_req(input bit w, input bit b, input bit s, input int a, input logic [15:0] wd);
    bit f;
    logic [15:0] want;
    int r0, w0, p0;
    f = model_fault(a, b);
    want = (w || f) ? 16'h0 : model_load(a, b, s);
    @(negedge clk);
    chk("ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_byte = b;
    bus.req_signed = s;
    bus.req_addr = 16'(a);
    bus.req_wdata = wd;
    r0 = rd_cnt;
    w0 = wn_cnt;
    p0 = resp_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr = 16'($urandom);
    bus.req_write = ~w;
    bus.req_byte = ~b;
    bus.req_wdata = 16'($urandom);
    if (!f) begin
      chk("acc_ready", 32'(bus.req_ready), 0);
      chk("acc_addr", 32'(bus.mem_address), 32'(a));
      chk("acc_rd", 32'(bus.mem_rd), 32'(!w));
      chk("acc_wn", 32'(bus.mem_wn), 32'(w));
      chk("acc_mode", 32'(bus.mem_mode), 32'(b));
      chk("acc_wdata", 32'(bus.mem_write_data), w ? 32'(wd) : 0);
      @(posedge clk);
      #1;
    end
    chk("resp_valid", 32'(bus.resp_valid), 1);
    chk("resp_fault", 32'(bus.resp_fault), 32'(f));
    chk("resp_data", 32'(bus.resp_data), 32'(want));
    chk("resp_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    chk("post_valid", 32'(bus.resp_valid), 0);
    chk("post_data", 32'(bus.resp_data), 0);
    chk("post_fault", 32'(bus.resp_fault), 0);
    chk("post_ready", 32'(bus.req_ready), 1);
    chk("rd_strobes", 32'(rd_cnt - r0), 32'(!f && !w));
    chk("wn_strobes", 32'(wn_cnt - w0), 32'(!f && w));
    chk("resp_pulses", 32'(resp_cnt - p0), 1);
    if (w && !f) begin
      if (b) ref_mem[a] = wd[7:0];
      else begin
        ref_mem[a] = wd[15:8];
        ref_mem[a + 1] = wd[7:0];
      end
    end
  endtask

  initial begin
    bit acc, pend;
    logic [15:0] acc_addr;
    int p0, w0;
    for (int i = 0; i < 2048; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[i] = ref_mem[i];
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    #2;
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_data", 32'(bus.resp_data), 0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_mem_wn", 32'(bus.mem_wn), 0);
    chk("rst_mem_addr", 32'(bus.mem_address), 0);
    chk("rst_mem_mode", 32'(bus.mem_mode), 0);
    chk("rst_mem_wdata", 32'(bus.mem_write_data), 0);
    @(negedge clk);
    rst = 1'b0;

    do_req(1, 0, 0, 16'h0010, 16'hBEEF);
    do_req(0, 0, 0, 16'h0010, 16'h0);
    do_req(1, 1, 0, 16'h0021, 16'h3C80);
    do_req(0, 1, 1, 16'h0021, 16'h0);
    do_req(0, 1, 0, 16'h0021, 16'h0);
    do_req(0, 0, 0, 16'h0020, 16'h0);
    do_req(0, 0, 0, 2047, 16'h0);
    do_req(0, 0, 0, 2046, 16'h0);
    do_req(1, 1, 0, 2048, 16'h0055);
    do_req(0, 1, 1, 2047, 16'h0);
    do_req(1, 0, 0, 16'h0101, 16'hA5C3);
    do_req(0, 0, 0, 16'h0101, 16'h0);

    // back-to-back loads with req_valid held high
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_byte = 1'b0;
    bus.req_addr = 16'($urandom_range(0, 2000));
    pend = 1'b0;
    acc_addr = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pend) begin
        chk("b2b_addr_held", 32'(bus.mem_address), 32'(acc_addr));
        pend = 1'b0;
      end
      acc = bus.req_ready;
      chk("b2b_accept", 32'(acc), 32'(c % 3 == 0));
      if (acc) acc_addr = bus.req_addr;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.req_addr = 16'($urandom_range(0, 2000));
        pend = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset during the ACCESS cycle of a store, before its commit negedge
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_byte = 1'b0;
    bus.req_addr = 16'h0030;
    bus.req_wdata = 16'h1234;
    p0 = resp_cnt;
    w0 = wn_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("abort_wn_pre", 32'(bus.mem_wn), 1);
    rst = 1'b1;
    #1;
    chk("abort_wn", 32'(bus.mem_wn), 0);
    chk("abort_addr", 32'(bus.mem_address), 0);
    chk("abort_wdata", 32'(bus.mem_write_data), 0);
    chk("abort_ready", 32'(bus.req_ready), 1);
    chk("abort_resp", 32'(bus.resp_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_resp", 32'(resp_cnt - p0), 0);
    chk("abort_no_commit", 32'(wn_cnt - w0), 0);
    do_req(0, 0, 0, 16'h0030, 16'h0);

    for (int i = 0; i < 40; i++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2040, 2055)) : int'($urandom_range(0, 63));
      do_req(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
    end

    chk("strobe_exclusive", 32'(excl_bad), 0);
    chk("mem_zero_outside_access", 32'(idle_bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
